// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Divide tracking is enabled by defining HAZ_MULDIV_EN.
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_CYCLES_DEF = 32;
  localparam int unsigned CNT_W          = 8;
  localparam int unsigned REG_W          = 5;
  localparam logic [REG_W-1:0] REG_X0    = 5'd0;

endpackage

// File: rtl/hazard_div_timer.sv
// Multi-cycle divide occupancy tracker: state register and cycle counter.
// Flops exist only when HAZ_MULDIV_EN is defined; otherwise outputs are tied low.
module hazard_div_timer
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done
);

`ifdef HAZ_MULDIV_EN
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt holds the busy cycles still to run after the current one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cnt_d   = CNT_LOAD;
            state_d = (CNT_LOAD == '0) ? DIV_DONE : DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_d == '0) begin
            state_d = DIV_DONE;
          end
        end
        DIV_DONE: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign busy = (state_q == DIV_BUSY);
  assign done = (state_q == DIV_DONE);
`else
  logic unused_timer;
  assign unused_timer = ^{clk, rst, start, abort, CNT_W'(DIV_CYCLES)};
  assign busy = 1'b0;
  assign done = 1'b0;
`endif

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage core: load-use stall, branch flush, divide freeze.
// Divide freeze is compiled in only when HAZ_MULDIV_EN is defined.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             idex_mem_read,
  input  logic             idex_is_div,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             bubble_sel,
  output logic             idex_hold,
  output logic             div_busy,
  output logic             div_done
);

  logic div_req;
  logic busy, done;
  logic freeze;
  logic load_use;

`ifdef HAZ_MULDIV_EN
  assign div_req = idex_is_div;
`else
  logic unused_top;
  assign unused_top = idex_is_div;
  assign div_req    = 1'b0;
`endif

  hazard_div_timer #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_timer (
    .clk  (clk),
    .rst  (rst),
    .start(div_req),
    .abort(branch_taken),
    .busy (busy),
    .done (done)
  );

  // Entry cycle (IDLE with a divide in EX) freezes as well as the busy cycles
  assign freeze   = (!busy && !done && div_req) || busy;
  assign load_use = idex_mem_read && (idex_rd != REG_X0) &&
                    ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    bubble_sel = 1'b0;
    idex_hold  = 1'b0;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      bubble_sel = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      bubble_sel = 1'b1;
    end else if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_hold  = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble_sel = 1'b1;
    end
  end

  assign div_busy = busy && !rst;
  assign div_done = done && !rst;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl; expectations adapt to HAZ_MULDIV_EN.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       idex_mem_read, idex_is_div, branch_taken;
  logic       pc_write, ifid_write, ifid_flush, bubble_sel, idex_hold, div_busy, div_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] v;
    string      tag;
  } exp_t;
  exp_t sb[$];

`ifdef HAZ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  // {pc_write, ifid_write, ifid_flush, bubble_sel, idex_hold, div_busy, div_done}
  localparam logic [6:0] NORM    = 7'b1100000;
  localparam logic [6:0] LU      = 7'b0001000;
  localparam logic [6:0] RSTV    = 7'b0011000;
  localparam logic [6:0] BR      = 7'b1111000;
  localparam logic [6:0] BR_BUSY = 7'b1111010;
  localparam logic [6:0] F0      = 7'b0000100;
  localparam logic [6:0] FB      = 7'b0000110;
  localparam logic [6:0] DN      = 7'b1100001;
  localparam logic [6:0] LU_DN   = 7'b0001001;

  hazard_stall_ctrl #(.DIV_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifid_rs1     (ifid_rs1),
    .ifid_rs2     (ifid_rs2),
    .idex_rd      (idex_rd),
    .idex_mem_read(idex_mem_read),
    .idex_is_div  (idex_is_div),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .bubble_sel   (bubble_sel),
    .idex_hold    (idex_hold),
    .div_busy     (div_busy),
    .div_done     (div_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic mr, input logic dv, input logic br, input logic r,
                      input logic [6:0] ev, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    ifid_rs1      = rs1;
    ifid_rs2      = rs2;
    idex_rd       = rd;
    idex_mem_read = mr;
    idex_is_div   = dv;
    branch_taken  = br;
    rst           = r;
    e.v   = ev;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Monitor: outputs are combinational, presented every cycle; sample mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [6:0] got;
      e   = sb.pop_front();
      got = {pc_write, ifid_write, ifid_flush, bubble_sel, idex_hold, div_busy, div_done};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s got=%b exp=%b (pc,ifw,flush,bub,hold,busy,done)", e.tag, got, e.v);
      end
    end
  end

  initial begin
    rst = 1'b1; ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0;
    idex_mem_read = 1'b0; idex_is_div = 1'b0; branch_taken = 1'b0;

    step(0, 0, 0, 0, 0, 0, 1, RSTV, "reset0");
    step(0, 0, 0, 0, 0, 0, 1, RSTV, "reset1");
    step(1, 2, 3, 0, 0, 0, 0, NORM, "normal");

    // Load-use variants
    step(1, 5, 5, 1, 0, 0, 0, LU,   "lu_rs2");
    step(1, 2, 5, 0, 0, 0, 0, NORM, "lu_release");
    step(7, 3, 7, 1, 0, 0, 0, LU,   "lu_rs1");
    step(0, 0, 0, 1, 0, 0, 0, NORM, "lu_x0");
    step(5, 5, 5, 0, 0, 0, 0, NORM, "no_load");
    step(5, 6, 5, 1, 0, 1, 0, BR,   "br_over_lu");

    // Single divide
    step(1, 2, 3, 0, 1, 0, 0, MD ? F0 : NORM, "div_c0");
    step(1, 2, 3, 0, 1, 0, 0, MD ? FB : NORM, "div_c1");
    step(1, 2, 3, 0, 1, 0, 0, MD ? FB : NORM, "div_c2");
    step(1, 2, 3, 0, 1, 0, 0, MD ? FB : NORM, "div_c3");
    step(1, 2, 3, 0, 1, 0, 0, MD ? DN : NORM, "div_c4");
    step(1, 2, 3, 0, 0, 0, 0, NORM, "div_after");

    // Back-to-back divides, no gap
    for (int k = 0; k < 2; k++) begin
      step(1, 2, 3, 0, 1, 0, 0, MD ? F0 : NORM, "b2b_c0");
      step(1, 2, 3, 0, 1, 0, 0, MD ? FB : NORM, "b2b_c1");
      step(1, 2, 3, 0, 1, 0, 0, MD ? FB : NORM, "b2b_c2");
      step(1, 2, 3, 0, 1, 0, 0, MD ? FB : NORM, "b2b_c3");
      step(1, 2, 3, 0, 1, 0, 0, MD ? DN : NORM, "b2b_c4");
    end
    step(1, 2, 3, 0, 0, 0, 0, NORM, "b2b_after");

    // Branch aborts a divide at cycle 2
    step(1, 2, 3, 0, 1, 0, 0, MD ? F0 : NORM, "abort_c0");
    step(1, 2, 3, 0, 1, 0, 0, MD ? FB : NORM, "abort_c1");
    step(1, 2, 3, 0, 0, 1, 0, MD ? BR_BUSY : BR, "abort_br");
    step(1, 2, 3, 0, 0, 0, 0, NORM, "abort_c3");
    step(1, 2, 3, 0, 0, 0, 0, NORM, "abort_c4");

    // Branch on the divide's entry cycle: branch wins, no divide started
    step(1, 2, 3, 0, 1, 1, 0, BR,   "br_on_start");
    step(1, 2, 3, 0, 0, 0, 0, NORM, "br_on_start_next");

    // Reset mid-divide
    step(1, 2, 3, 0, 1, 0, 0, MD ? F0 : NORM, "rstmid_c0");
    step(1, 2, 3, 0, 1, 0, 0, MD ? FB : NORM, "rstmid_c1");
    step(1, 2, 3, 0, 1, 0, 1, RSTV, "rstmid_r0");
    step(1, 2, 3, 0, 1, 0, 1, RSTV, "rstmid_r1");
    step(1, 2, 3, 0, 0, 0, 0, NORM, "rstmid_resume");

    // Load-use visible in DIV_DONE and then in IDLE
    step(1, 2, 3, 0, 1, 0, 0, MD ? F0 : NORM, "dlu_c0");
    step(1, 2, 3, 0, 1, 0, 0, MD ? FB : NORM, "dlu_c1");
    step(1, 2, 3, 0, 1, 0, 0, MD ? FB : NORM, "dlu_c2");
    step(1, 2, 3, 0, 1, 0, 0, MD ? FB : NORM, "dlu_c3");
    step(7, 2, 7, 1, 0, 0, 0, MD ? LU_DN : LU, "dlu_done");
    step(7, 2, 7, 1, 0, 0, 0, LU,   "dlu_idle");
    step(7, 2, 7, 0, 0, 0, 0, NORM, "dlu_clear");

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without completion");
    $fatal(1, "timeout");
  end

endmodule
